move_scan_sequencer: RTL and testbench
======================================

# move_scan_sequencer

Sequences the square array's move-generation datapath for one search node. On `start` it enables the array and waits a fixed settle time for attack rays and knight hops to propagate. It then walks all 64 squares, snapshots each square's 16 move registers, and streams every non-empty move belonging to `engineColor` to the downstream move list over a valid/ready handshake. It sits between the square array (through an external per-square move mux) and the move buffer/evaluator.

## Interface
- `SETTLE_CYCLES`, default 16: cycles the array is enabled before scanning starts (must be ≥1).
- `NUM_SQUARES`, default 64: squares scanned, indices 0..NUM_SQUARES-1.
- `clk`  in  1  system clock; all logic on rising edge.
- `clear`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a scan; honoured only in IDLE.
- `engineColor`  in  1  side to move (WHITE=1, BLACK=0); sampled on accepted `start`.
- `array_enable`  out  1  enable to the square array; high in SETTLE, LOAD, EMIT, NEXT.
- `square_sel`  out  6  square whose moves drive `move_bus`.
- `move_bus`  in  512  16 move words of the selected square; slot k = bits [32k+31:32k]; order U,D,L,R,UL,UR,DL,DR,UUL,UUR,LLU,RRU,DDL,DDR,LLD,RRD (k=0..15).
- `move_out`  out  32  current move word.
- `move_valid`  out  1  `move_out` valid.
- `move_ready`  in  1  downstream accepts.
- `move_count`  out  11  moves emitted in the current/last scan.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at scan end.

## Operation
- Move word fields: [29:24] captured piece, [21:16] final position, [13:8] initial piece (bit 13 = colour), [5:0] initial position. A word equal to 32'h0000_0000 is empty.
- States: IDLE, SETTLE, LOAD, EMIT, NEXT, DONE.
- IDLE: on `start`, latch `engineColor`, clear `move_count`, zero the settle counter, and go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to LOAD with `square_sel`=0.
- LOAD: register all 16 words of `move_bus` into the snapshot. Set pending bit k = (word k ≠ 0) && (word k[13] == latched colour). If any bit is pending, go to EMIT, otherwise go to NEXT.
- EMIT: present the lowest-index pending slot. On `move_valid && move_ready`, clear that bit and increment `move_count`. When the last pending bit clears, go to NEXT.
- NEXT: if `square_sel` == NUM_SQUARES-1, go to DONE. Otherwise increment `square_sel` and go to LOAD.
- DONE: pulse `done` and go to IDLE. `move_count` holds until the next accepted `start`.
- `start` while busy is ignored. `engineColor` changes mid-scan have no effect.
- `clear` in any state: go to IDLE and zero every output and all internal state. An in-flight move is dropped, not completed.

## Timing
- Reset value of every output is 0.
- Accepted `start` at cycle t:
  - `busy` and `array_enable` are high from t+1.
  - First LOAD occurs at t+1+SETTLE_CYCLES.
  - Earliest `move_valid` is one cycle after LOAD.
- The snapshot is taken at the end of LOAD. `square_sel` is stable for the whole LOAD cycle, so the external mux must be combinational.
- Cost per square: LOAD (1) + emitted moves (1 each when ready is high) + NEXT (1).
  - Square with no pending move: 2 cycles.
  - Empty board: DONE at LOAD0 + 128 cycles.
- Handshake rules:
  - Once `move_valid` rises, `move_out` is stable until the handshake completes.
  - `move_valid` never depends combinationally on `move_ready`.
  - Back-to-back transfers are allowed: one move per cycle while ready is high.
- `move_count` width covers the maximum of 64×16 = 1024; it never wraps.

## Structure
- Shared package `chess_pkg` holds:
  - WHITE/BLACK, piece codes (PAWN 00010, KNIGHT 00001, BISHOP 01000, ROOK 10000, QUEEN 11000, KING 00100), EMPTY_MOVE.
  - Move field bit positions.
  - Direction slot indices 0..15.
  - The FSM state enumeration.
- One sub-module, `move_slot_picker`: a 16-bit lowest-set-bit priority encoder that outputs a 4-bit index and an any-pending flag. The FSM uses it in EMIT and LOAD.

## Test plan
- Reset:
  - Stimulus: hold `clear` for 2 cycles with `start` high.
  - Response: all outputs are 0; after `clear` falls, `busy` stays 0 until a fresh `start`.
- Settle timing:
  - Stimulus: SETTLE_CYCLES=4, `start` at cycle 10.
  - Response: `array_enable` rises at 11; `square_sel`=0 LOAD at 15; first `move_valid` at 16.
- Colour filter and ordering:
  - Stimulus: `engineColor`=BLACK; square 0 has slot 1 = 32'h000C1814 (black queen 20→12), slot 5 = 32'h000C3814 (white piece), slot 9 = 32'h002B0114.
  - Response: only 32'h000C1814 then 32'h002B0114 are emitted; `move_count`=2.
- Backpressure:
  - Stimulus: hold `move_ready` low for 5 cycles while `move_valid` is high.
  - Response: `move_out` is unchanged and `move_count` does not increment; after `move_ready` rises, the next move follows in the next cycle.
- Full load:
  - Stimulus: all 1024 slots hold valid black moves; `move_ready` tied high.
  - Response: 1024 transfers; `move_count`=1024; exactly one `done` pulse, at first LOAD + 64×18 cycles.
- Abort:
  - Stimulus: assert `clear` during EMIT on square 7.
  - Response: the next cycle has `move_valid`=0, `busy`=0, `move_count`=0; a subsequent `start` performs a full scan correctly.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess encodings for the move-generation datapath: colours, piece
// codes, move-word field positions, direction slot indices and the scan FSM
// state set.
package chess_pkg;

  localparam logic WHITE = 1'b1;
  localparam logic BLACK = 1'b0;

  localparam logic [4:0] PAWN   = 5'b00010;
  localparam logic [4:0] KNIGHT = 5'b00001;
  localparam logic [4:0] BISHOP = 5'b01000;
  localparam logic [4:0] ROOK   = 5'b10000;
  localparam logic [4:0] QUEEN  = 5'b11000;
  localparam logic [4:0] KING   = 5'b00100;

  localparam logic [31:0] EMPTY_MOVE = 32'h0000_0000;

  // Move word layout
  localparam int CAPT_MSB        = 29;
  localparam int CAPT_LSB        = 24;
  localparam int FINAL_MSB       = 21;
  localparam int FINAL_LSB       = 16;
  localparam int PIECE_MSB       = 13;
  localparam int PIECE_LSB       = 8;
  localparam int PIECE_COLOR_BIT = 13;
  localparam int INIT_MSB        = 5;
  localparam int INIT_LSB        = 0;

  // Direction slots within a square's 16-word move group
  localparam int NUM_SLOTS = 16;
  localparam int SLOT_U    = 0;
  localparam int SLOT_D    = 1;
  localparam int SLOT_L    = 2;
  localparam int SLOT_R    = 3;
  localparam int SLOT_UL   = 4;
  localparam int SLOT_UR   = 5;
  localparam int SLOT_DL   = 6;
  localparam int SLOT_DR   = 7;
  localparam int SLOT_UUL  = 8;
  localparam int SLOT_UUR  = 9;
  localparam int SLOT_LLU  = 10;
  localparam int SLOT_RRU  = 11;
  localparam int SLOT_DDL  = 12;
  localparam int SLOT_DDR  = 13;
  localparam int SLOT_LLD  = 14;
  localparam int SLOT_RRD  = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LOAD,
    ST_EMIT,
    ST_NEXT,
    ST_DONE
  } scan_state_e;

  // A move is worth emitting when it is present and moves a piece of our colour.
  function automatic logic move_belongs(input logic [31:0] word, input logic color);
    return (word != EMPTY_MOVE) && (word[PIECE_COLOR_BIT] == color);
  endfunction

endpackage

// File: rtl/move_slot_picker.sv
// Lowest-set-bit priority encoder over a square's 16 pending move slots.
module move_slot_picker (
  input  logic [15:0] pending_i,
  output logic [3:0]  index_o,
  output logic        any_o
);

  // Scan from the top down so the lowest pending slot wins.
  always_comb begin
    index_o = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (pending_i[k]) index_o = 4'(k);
    end
    any_o = |pending_i;
  end

endmodule

// File: rtl/move_scan_sequencer.sv
// Walks every square of the array after a settle period, snapshots each
// square's 16 move words and streams the side-to-move's moves downstream
// over a valid/ready handshake.
module move_scan_sequencer
  import chess_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int NUM_SQUARES   = 64
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         start,
  input  logic         engineColor,
  output logic         array_enable,
  output logic [5:0]   square_sel,
  input  logic [511:0] move_bus,
  output logic [31:0]  move_out,
  output logic         move_valid,
  input  logic         move_ready,
  output logic [10:0]  move_count,
  output logic         busy,
  output logic         done
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [5:0]    SQ_LAST     = 6'(NUM_SQUARES - 1);

  scan_state_e   state_q;
  logic          color_q;
  logic [SW-1:0] settle_q;
  logic [5:0]    sel_q;
  logic [15:0]   pending_q;
  logic [3:0]    slot_q;
  logic [31:0]   snap_q [NUM_SLOTS];
  logic [31:0]   move_out_q;
  logic          valid_q;
  logic [10:0]   count_q;
  logic          busy_q;
  logic          enable_q;
  logic          done_q;

  logic [31:0]   bus_word [NUM_SLOTS];
  logic [15:0]   load_pending_d;
  logic [15:0]   pending_d;
  logic [15:0]   pick_in;
  logic [3:0]    pick_idx;
  logic          pick_any;
  logic          handshake;

  // Split the bus into slot words and qualify each against the latched colour.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    assign bus_word[gi]       = move_bus[32*gi +: 32];
    assign load_pending_d[gi] = move_belongs(bus_word[gi], color_q);
  end

  // Pending set once the slot currently on the output has been taken.
  assign pending_d = pending_q & ~(16'd1 << slot_q);
  assign handshake = valid_q & move_ready;
  assign pick_in   = (state_q == ST_LOAD) ? load_pending_d : pending_d;

  move_slot_picker u_picker (
    .pending_i (pick_in),
    .index_o   (pick_idx),
    .any_o     (pick_any)
  );

  // Scan FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= ST_IDLE;
      color_q    <= 1'b0;
      settle_q   <= '0;
      sel_q      <= '0;
      pending_q  <= '0;
      slot_q     <= '0;
      move_out_q <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      enable_q   <= 1'b0;
      done_q     <= 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) snap_q[k] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            color_q  <= engineColor;
            count_q  <= '0;
            settle_q <= '0;
            sel_q    <= '0;
            busy_q   <= 1'b1;
            enable_q <= 1'b1;
            state_q  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            sel_q   <= '0;
            state_q <= ST_LOAD;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        ST_LOAD: begin
          for (int k = 0; k < NUM_SLOTS; k++) snap_q[k] <= bus_word[k];
          pending_q  <= load_pending_d;
          slot_q     <= pick_idx;
          // The snapshot is not written yet, so the first word comes from the bus.
          move_out_q <= pick_any ? bus_word[pick_idx] : '0;
          valid_q    <= pick_any;
          state_q    <= pick_any ? ST_EMIT : ST_NEXT;
        end
        ST_EMIT: begin
          if (handshake) begin
            count_q   <= count_q + 1'b1;
            pending_q <= pending_d;
            if (pick_any) begin
              slot_q     <= pick_idx;
              move_out_q <= snap_q[pick_idx];
            end else begin
              valid_q    <= 1'b0;
              move_out_q <= '0;
              state_q    <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          if (sel_q == SQ_LAST) begin
            enable_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            sel_q   <= sel_q + 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign array_enable = enable_q;
  assign square_sel   = sel_q;
  assign move_out     = move_out_q;
  assign move_valid   = valid_q;
  assign move_count   = count_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_move_scan_sequencer.sv
// Directed and randomized checks of move_scan_sequencer against a board model.
module tb_move_scan_sequencer;
  import chess_pkg::*;

  logic         clk = 1'b0;
  logic         clear, start, engineColor, move_ready;
  logic         array_enable, move_valid, busy, done;
  logic [5:0]   square_sel;
  logic [511:0] move_bus;
  logic [31:0]  move_out;
  logic [10:0]  move_count;

  logic [31:0]  board [64][16];
  logic [31:0]  exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  move_scan_sequencer #(.SETTLE_CYCLES(4), .NUM_SQUARES(64)) dut (
    .clk          (clk),
    .clear        (clear),
    .start        (start),
    .engineColor  (engineColor),
    .array_enable (array_enable),
    .square_sel   (square_sel),
    .move_bus     (move_bus),
    .move_out     (move_out),
    .move_valid   (move_valid),
    .move_ready   (move_ready),
    .move_count   (move_count),
    .busy         (busy),
    .done         (done)
  );

  // External combinational per-square move mux.
  always_comb begin
    move_bus = '0;
    for (int k = 0; k < 16; k++) move_bus[32*k +: 32] = board[square_sel][k];
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rand_move(input logic col);
    logic [31:0] w;
    w = $urandom;
    w[31:30] = 2'b0; w[23:22] = 2'b0; w[15:14] = 2'b0; w[7:6] = 2'b0;
    w[13] = col;
    if (w == 32'h0) w = 32'h1;
    return w;
  endfunction

  task automatic clear_board();
    for (int s = 0; s < 64; s++) for (int k = 0; k < 16; k++) board[s][k] = 32'h0;
  endtask

  task automatic random_board();
    for (int s = 0; s < 64; s++)
      for (int k = 0; k < 16; k++) begin
        case ($urandom_range(0, 3))
          0:       board[s][k] = 32'h0;
          1:       board[s][k] = rand_move(WHITE);
          default: board[s][k] = rand_move(BLACK);
        endcase
      end
  endtask

  // Reference: squares in ascending order, slots in ascending order, keep
  // non-empty words whose piece colour matches the side to move.
  task automatic build_expected(input logic col);
    exp_q.delete();
    for (int s = 0; s < 64; s++)
      for (int k = 0; k < 16; k++)
        if (board[s][k] != 32'h0 && board[s][k][13] == col) exp_q.push_back(board[s][k]);
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        at = cyc;
        break;
      end
      step();
    end
    chk("done_timeout", {31'b0, done}, 32'd1);
  endtask

  // One full scan; exp_off < 0 skips the done-cycle check.
  task automatic run_scan(input logic col, input bit rand_ready, input int exp_off);
    int got, t1, k;
    logic [31:0] hold;
    bit holding;
    build_expected(col);
    engineColor = col;
    start = 1'b1;
    step();
    start = 1'b0;
    engineColor = ~col;
    t1 = cyc;
    got = 0;
    holding = 1'b0;
    hold = '0;
    for (k = 0; k < 6000; k++) begin
      if (done) break;
      move_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (move_valid) begin
        if (holding) chk("hold_stable", move_out, hold);
        if (move_ready) begin
          if (got < exp_q.size()) chk("move_word", move_out, exp_q[got]);
          $display("xfer %0d sq=%0d word=%08h", got, square_sel, move_out);
          got++;
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          hold = move_out;
        end
      end
      step();
    end
    chk("scan_done", {31'b0, done}, 32'd1);
    chk("scan_xfers", got, exp_q.size());
    chk("scan_count", move_count, exp_q.size());
    if (exp_off >= 0) chk("done_cycle", cyc - t1, exp_off);
    step();
    chk("done_single", {31'b0, done}, 32'd0);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    move_ready = 1'b0;
  endtask

  initial begin
    int t1, dc, k;
    logic [31:0] w2, w4, w11, first;

    // Reset with start held high.
    clear = 1'b1; start = 1'b1; engineColor = WHITE; move_ready = 1'b0;
    clear_board();
    step();
    step();
    chk("rst_move_out", move_out, 32'h0);
    chk("rst_valid", {31'b0, move_valid}, 32'd0);
    chk("rst_count", {21'b0, move_count}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_enable", {31'b0, array_enable}, 32'd0);
    chk("rst_sel", {26'b0, square_sel}, 32'd0);
    clear = 1'b0; start = 1'b0;
    repeat (3) step();
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    // Settle timing, colour filter and ordering.
    board[0][1] = 32'h000C1814;
    board[0][5] = 32'h000C3814;
    board[0][9] = 32'h002B0114;
    move_ready = 1'b1; engineColor = BLACK; start = 1'b1;
    step();
    start = 1'b0; engineColor = WHITE;
    t1 = cyc;
    chk("t1_busy", {31'b0, busy}, 32'd1);
    chk("t1_enable", {31'b0, array_enable}, 32'd1);
    chk("t1_valid", {31'b0, move_valid}, 32'd0);
    repeat (4) step();
    chk("load_valid", {31'b0, move_valid}, 32'd0);
    chk("load_sel", {26'b0, square_sel}, 32'd0);
    step();
    chk("first_valid", {31'b0, move_valid}, 32'd1);
    chk("first_word", move_out, 32'h000C1814);
    step();
    chk("second_word", move_out, 32'h002B0114);
    chk("second_count", {21'b0, move_count}, 32'd1);
    step();
    chk("sq0_valid_low", {31'b0, move_valid}, 32'd0);
    chk("sq0_count", {21'b0, move_count}, 32'd2);
    wait_done(3000, dc);
    chk("colour_done_cycle", dc - t1, 32'd134);
    chk("colour_count", {21'b0, move_count}, 32'd2);
    step();
    chk("colour_done_single", {31'b0, done}, 32'd0);

    // Backpressure on square 3.
    clear_board();
    w2 = rand_move(BLACK); w4 = rand_move(BLACK); w11 = rand_move(BLACK);
    board[3][2] = w2; board[3][4] = w4; board[3][11] = w11;
    board[3][7] = rand_move(WHITE);
    move_ready = 1'b0; engineColor = BLACK; start = 1'b1;
    step();
    start = 1'b0;
    for (k = 0; k < 200; k++) begin
      if (move_valid) break;
      step();
    end
    chk("bp_valid", {31'b0, move_valid}, 32'd1);
    first = move_out;
    chk("bp_first", first, w2);
    repeat (5) begin
      step();
      chk("bp_hold_word", move_out, w2);
      chk("bp_hold_count", {21'b0, move_count}, 32'd0);
    end
    move_ready = 1'b1;
    step();
    chk("bp_next_word", move_out, w4);
    chk("bp_next_count", {21'b0, move_count}, 32'd1);
    step();
    chk("bp_third_word", move_out, w11);
    step();
    chk("bp_end_valid", {31'b0, move_valid}, 32'd0);
    chk("bp_end_count", {21'b0, move_count}, 32'd3);
    wait_done(3000, dc);
    step();

    // Empty board: two cycles per square.
    clear_board();
    run_scan(BLACK, 1'b0, 132);

    // Random boards, random backpressure, both colours.
    for (int it = 0; it < 4; it++) begin
      random_board();
      run_scan(it[0] ? WHITE : BLACK, 1'b1, -1);
    end

    // Full load: every slot a black move.
    for (int s = 0; s < 64; s++) for (int j = 0; j < 16; j++) board[s][j] = rand_move(BLACK);
    run_scan(BLACK, 1'b0, 4 + 64 * 18);

    // Abort during EMIT on square 7.
    random_board();
    board[7][0] = rand_move(BLACK);
    move_ready = 1'b1; engineColor = BLACK; start = 1'b1;
    step();
    start = 1'b0;
    for (k = 0; k < 3000; k++) begin
      if (square_sel == 6'd7 && move_valid) break;
      step();
    end
    chk("abort_reached", {31'b0, move_valid}, 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("abort_valid", {31'b0, move_valid}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_count", {21'b0, move_count}, 32'd0);
    chk("abort_enable", {31'b0, array_enable}, 32'd0);
    step();
    random_board();
    run_scan(WHITE, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
